// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM March-test BIST controller.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      M0_W,
      M1_UP,
      M2_DN,
      M3_RD,
      DRAIN,
      DONE
   } state_t;

   typedef enum logic {
      PH_RD,
      PH_WR
   } phase_t;

   // Sliced down to the byte-enable width at the point of use.
   localparam logic [31:0] WEN_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: carries {addr, expected} alongside the RAM read latency,
// compares RD as each entry emerges and records first failure plus error count.
module ram_bist_cmp
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                push,
   input  logic [ADDR_W-1:0]   push_addr,
   input  logic [DATA_W-1:0]   push_exp,
   input  logic [DATA_W-1:0]   rd,
   output logic                fail,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [ERRCNT_W-1:0] err_count
);

   logic [ADDR_W-1:0]     addr_p [RD_LATENCY];
   logic [DATA_W-1:0]     exp_p  [RD_LATENCY];
   logic [RD_LATENCY-1:0] vld_p;
   logic                  miss;

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
      return (&v) ? v : v + ERRCNT_W'(1);
   endfunction

   assign miss = vld_p[RD_LATENCY-1] && (rd != exp_p[RD_LATENCY-1]);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld_p     <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         err_count <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            addr_p[i] <= '0;
            exp_p[i]  <= '0;
         end
      end else begin
         // stage 0 captures the read issue; the last stage lines up with RD
         vld_p[0]  <= push;
         addr_p[0] <= push_addr;
         exp_p[0]  <= push_exp;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            addr_p[i] <= addr_p[i-1];
            exp_p[i]  <= exp_p[i-1];
         end
         if (miss) begin
            fail      <= 1'b1;
            err_count <= sat_inc(err_count);
            if (!fail) begin
               fail_addr <= addr_p[RD_LATENCY-1];
               fail_data <= rd;
            end
         end
      end
   end

endmodule

// File: rtl/ram_bist_march_ctrl.sv
// March BIST initiator: w P; up(r P, w ~P); down(r ~P, w P); r P over the whole RAM,
// driving the RAM write/read ports and reporting the result through ram_bist_cmp.
module ram_bist_march_ctrl
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int WEN_W      = 2,
   parameter int RD_LATENCY = 1,
   parameter int ERRCNT_W   = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Start,
   input  logic [DATA_W-1:0]   Pattern,
   output logic                Busy,
   output logic                Done,
   output logic                Fail,
   output logic [ADDR_W-1:0]   FailAddr,
   output logic [DATA_W-1:0]   FailData,
   output logic [ERRCNT_W-1:0] ErrCount,
   output logic [ADDR_W-1:0]   WA,
   output logic [DATA_W-1:0]   WD,
   output logic [WEN_W-1:0]    WEN,
   output logic                WClk_En,
   output logic [ADDR_W-1:0]   RA,
   output logic                RClk_En,
   input  logic [DATA_W-1:0]   RD
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam int                DRAIN_W   = $clog2(RD_LATENCY + 1);

   state_t              state, state_n;
   phase_t              phase, phase_n;
   logic [ADDR_W-1:0]   addr, addr_n;
   logic [DRAIN_W-1:0]  drain_cnt, drain_n;
   logic [DATA_W-1:0]   pat;
   logic                start_ok;
   logic                wr_en;
   logic                rd_en;
   logic [DATA_W-1:0]   exp_data;

   assign start_ok = Start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         phase     <= PH_RD;
         addr      <= '0;
         drain_cnt <= '0;
         pat       <= '0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         addr      <= addr_n;
         drain_cnt <= drain_n;
         if (start_ok) pat <= Pattern;
      end
   end

   // The terminal address of each element is what moves the FSM on; no modulo wrap.
   always_comb begin
      state_n = state;
      phase_n = phase;
      addr_n  = addr;
      drain_n = drain_cnt;
      unique case (state)
         IDLE, DONE: begin
            if (Start) begin
               state_n = M0_W;
               addr_n  = '0;
               phase_n = PH_RD;
            end
         end
         M0_W: begin
            if (addr == ADDR_LAST) begin
               state_n = M1_UP;
               addr_n  = '0;
            end else begin
               addr_n = addr + ADDR_W'(1);
            end
         end
         M1_UP: begin
            if (phase == PH_RD) begin
               phase_n = PH_WR;
            end else begin
               phase_n = PH_RD;
               if (addr == ADDR_LAST) state_n = M2_DN;
               else                   addr_n  = addr + ADDR_W'(1);
            end
         end
         M2_DN: begin
            if (phase == PH_RD) begin
               phase_n = PH_WR;
            end else begin
               phase_n = PH_RD;
               if (addr == '0) state_n = M3_RD;
               else            addr_n  = addr - ADDR_W'(1);
            end
         end
         M3_RD: begin
            if (addr == ADDR_LAST) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               addr_n = addr + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_W'(RD_LATENCY - 1)) state_n = DONE;
            else                                       drain_n = drain_cnt + DRAIN_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   // Read and write phases alternate, so both enables are never high together.
   assign wr_en = (state == M0_W) ||
                  (((state == M1_UP) || (state == M2_DN)) && (phase == PH_WR));
   assign rd_en = (state == M3_RD) ||
                  (((state == M1_UP) || (state == M2_DN)) && (phase == PH_RD));

   assign exp_data = (state == M2_DN) ? ~pat : pat;

   assign Busy    = (state == M0_W) || (state == M1_UP) || (state == M2_DN) ||
                    (state == M3_RD) || (state == DRAIN);
   assign Done    = (state == DONE);
   assign WA      = addr;
   assign RA      = addr;
   assign WD      = (state == M1_UP) ? ~pat : pat;
   assign WEN     = wr_en ? WEN_ALL[WEN_W-1:0] : '0;
   assign WClk_En = wr_en;
   assign RClk_En = rd_en;

   ram_bist_cmp #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY),
      .ERRCNT_W   (ERRCNT_W)
   ) u_cmp (
      .clk       (Clk),
      .rst       (Rst),
      .clr       (start_ok),
      .push      (rd_en),
      .push_addr (addr),
      .push_exp  (exp_data),
      .rd        (RD),
      .fail      (Fail),
      .fail_addr (FailAddr),
      .fail_data (FailData),
      .err_count (ErrCount)
   );

endmodule
